merge: RTL and testbench



---
 rtl/merge.sv | 135 +++++++++++++
 tb/tb_merge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/merge.sv
// Lane-to-stream merger: gathers KERNEL_LENGTH parallel words per write and
// replays them lane-major (all of lane 0, then lane 1, ...) for the DMA writer.
module merge #(
   parameter int DATA_WIDTH    = 32,
   parameter int BURST_LENGTH  = 32,
   parameter int KERNEL_LENGTH = 3
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    wen,
   input  logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] din,
   input  logic                                    flush,
   output logic                                    full_flag,
   output logic                                    empty_flag,
   input  logic                                    ren,
   output logic                                    valid,
   output logic [DATA_WIDTH-1:0]                   dout,
   output logic [$clog2(KERNEL_LENGTH)-1:0]        lane_sel,
   output logic                                    burst_last
);

   localparam int AW = $clog2(BURST_LENGTH);
   localparam int LW = $clog2(KERNEL_LENGTH);

   localparam logic [0:0]    FILL  = 1'b0;
   localparam logic [0:0]    DRAIN = 1'b1;

   localparam logic [AW:0]   BL_C      = (AW+1)'(BURST_LENGTH);
   localparam logic [AW:0]   ONE_C     = (AW+1)'(1);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);
   localparam logic [LW-1:0] LANE_ONE  = LW'(1);
   localparam logic [LW-1:0] LAST_LANE = LW'(KERNEL_LENGTH-1);

   logic [DATA_WIDTH-1:0] r_mem [KERNEL_LENGTH][BURST_LENGTH];

   logic [0:0]            r_state;
   // Write pointer doubles as the fill count: both advance together and clear together.
   logic [AW:0]           r_wptr;
   logic [AW:0]           r_len;
   logic [LW-1:0]         r_rd_lane;
   logic [AW-1:0]         r_rd_idx;
   logic                  r_more;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [LW-1:0]         r_lane_sel;
   logic                  r_burst_last;

   logic                  w_full;
   logic                  w_wr;
   logic [AW:0]           w_cnt_next;
   logic                  w_load;
   logic                  w_rd_last_idx;
   logic                  w_rd_last_lane;

   assign w_full         = (r_state == DRAIN) || (r_wptr == BL_C);
   assign w_wr           = wen && !w_full;
   assign w_cnt_next     = r_wptr + {{AW{1'b0}}, w_wr};
   // The output register may be refilled when empty or being consumed this cycle.
   assign w_load         = (r_state == DRAIN) && (!r_valid || ren);
   assign w_rd_last_idx  = ({1'b0, r_rd_idx} == (r_len - ONE_C));
   assign w_rd_last_lane = (r_rd_lane == LAST_LANE);

   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int k = 0; k < KERNEL_LENGTH; k++) begin
            r_mem[k][r_wptr[AW-1:0]] <= din[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FILL;
         r_wptr       <= '0;
         r_len        <= '0;
         r_rd_lane    <= '0;
         r_rd_idx     <= '0;
         r_more       <= 1'b0;
         r_valid      <= 1'b0;
         r_dout       <= '0;
         r_lane_sel   <= '0;
         r_burst_last <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_wr) begin
                  r_wptr <= r_wptr + ONE_C;
               end
               if (r_wptr == BL_C || (flush && w_cnt_next != '0)) begin
                  r_state   <= DRAIN;
                  r_len     <= (r_wptr == BL_C) ? BL_C : w_cnt_next;
                  r_rd_lane <= '0;
                  r_rd_idx  <= '0;
                  r_more    <= 1'b1;
               end
            end
            default: begin
               if (w_load) begin
                  if (r_more) begin
                     r_dout       <= r_mem[r_rd_lane][r_rd_idx];
                     r_lane_sel   <= r_rd_lane;
                     r_burst_last <= w_rd_last_idx;
                     r_valid      <= 1'b1;
                     if (w_rd_last_idx) begin
                        r_rd_idx <= '0;
                        if (w_rd_last_lane) begin
                           r_more <= 1'b0;
                        end else begin
                           r_rd_lane <= r_rd_lane + LANE_ONE;
                        end
                     end else begin
                        r_rd_idx <= r_rd_idx + IDX_ONE;
                     end
                  end else begin
                     // Final word is leaving; the burst is done.
                     r_valid <= 1'b0;
                     if (r_valid) begin
                        r_state <= FILL;
                        r_wptr  <= '0;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign full_flag  = w_full;
   assign empty_flag = (r_state == FILL) && (r_wptr == '0);
   assign valid      = r_valid;
   assign dout       = r_dout;
   assign lane_sel   = r_lane_sel;
   assign burst_last = r_burst_last;

endmodule

// File: tb/tb_merge.sv
// Directed bench for merge: expected lane-major words are queued per burst and a
// negedge monitor pops and compares each transferred word.
module tb_merge;

   localparam int DW = 32;
   localparam int BL = 32;
   localparam int KL = 3;
   localparam int LW = 2;
   localparam int EW = DW + LW + 1;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                   wen = 1'b0;
   logic                   flush = 1'b0;
   logic                   ren = 1'b1;
   logic [KL-1:0][DW-1:0]  din = '0;
   logic                   full_flag;
   logic                   empty_flag;
   logic                   valid;
   logic [DW-1:0]          dout;
   logic [LW-1:0]          lane_sel;
   logic                   burst_last;

   merge #(.DATA_WIDTH(DW), .BURST_LENGTH(BL), .KERNEL_LENGTH(KL)) dut (
      .clk(clk), .rst(rst), .wen(wen), .din(din), .flush(flush),
      .full_flag(full_flag), .empty_flag(empty_flag), .ren(ren),
      .valid(valid), .dout(dout), .lane_sel(lane_sel), .burst_last(burst_last)
   );

   int vectors = 0;
   int miscompares = 0;
   int xfer_cnt = 0;
   int ren_mode = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ren driver: 0 = always high, 1 = pattern 1,0,0,1, 2 = always low
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge clk);
         #1;
         case (ren_mode)
            0: ren = 1'b1;
            1: begin
               ren = (phase == 0) || (phase == 3);
               phase = (phase + 1) % 4;
            end
            default: ren = 1'b0;
         endcase
      end
   end

   // scoreboard monitor
   initial begin
      logic          pv;
      logic          pr;
      logic [EW-1:0] pw;
      logic [EW-1:0] e;
      pv = 1'b0;
      pr = 1'b0;
      pw = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (pv && !pr) begin
               check("hold_stable", {valid, burst_last, lane_sel, dout}, {1'b1, pw});
            end
            if (valid && ren) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_word: got %h expected no output", dout);
               end else begin
                  e = exp_q.pop_front();
                  check("word", {burst_last, lane_sel, dout}, e);
                  xfer_cnt++;
               end
            end
         end
         pv = valid && !rst;
         pr = ren;
         pw = {burst_last, lane_sel, dout};
      end
   end

   // driver tasks
   task automatic push_burst(input logic [DW-1:0] base, input int n);
      for (int k = 0; k < KL; k++) begin
         for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = base + DW'(k * 256 + i);
            exp_q.push_back({(i == n - 1), LW'(k), w});
         end
      end
   endtask

   task automatic write_cycle(input logic [DW-1:0] base, input int i, input logic fl);
      @(posedge clk);
      #1;
      wen = 1'b1;
      flush = fl;
      for (int k = 0; k < KL; k++) din[k] = base + DW'(k * 256 + i);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
      wen = 1'b0;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(exp_q.size() == 0 && !valid) && c < budget);
      if (exp_q.size() != 0 || valid) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
      end else begin
         check({name, "_full_after"}, {63'd0, full_flag}, 64'd0);
         check({name, "_empty_after"}, {63'd0, empty_flag}, 64'd1);
      end
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_valid"}, {63'd0, valid}, 64'd0);
      check({name, "_dout"}, {32'd0, dout}, 64'd0);
      check({name, "_lane_sel"}, {62'd0, lane_sel}, 64'd0);
      check({name, "_burst_last"}, {63'd0, burst_last}, 64'd0);
      check({name, "_full"}, {63'd0, full_flag}, 64'd0);
      check({name, "_empty"}, {63'd0, empty_flag}, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int x0;
      int c;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset");

      // full burst, ren high
      push_burst(32'h0, BL);
      for (int i = 0; i < BL; i++) write_cycle(32'h0, i, 1'b0);
      idle_cycle();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!valid && lat < 10);
      check("first_word_latency", 64'(lat), 64'd3);
      wait_drain("full_burst", 200);

      // backpressure
      ren_mode = 1;
      push_burst(32'h10000, BL);
      for (int i = 0; i < BL; i++) write_cycle(32'h10000, i, 1'b0);
      idle_cycle();
      wait_drain("backpressure", 400);
      ren_mode = 0;

      // partial flush
      push_burst(32'h20000, 5);
      for (int i = 0; i < 5; i++) write_cycle(32'h20000, i, 1'b0);
      @(posedge clk);
      #1;
      wen = 1'b0;
      flush = 1'b1;
      idle_cycle();
      wait_drain("partial_flush", 100);

      // write together with flush
      push_burst(32'h30000, 5);
      for (int i = 0; i < 4; i++) write_cycle(32'h30000, i, 1'b0);
      write_cycle(32'h30000, 4, 1'b1);
      idle_cycle();
      wait_drain("write_flush", 100);

      // flush with nothing stored
      @(posedge clk);
      #1;
      flush = 1'b1;
      idle_cycle();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("empty_flush_valid", {63'd0, valid}, 64'd0);
      end

      // overflow with ren low
      ren_mode = 2;
      push_burst(32'h40000, BL);
      for (int i = 0; i < 40; i++) begin
         write_cycle(32'h40000, i, 1'b0);
         @(negedge clk);
         check("overflow_full", {63'd0, full_flag}, {63'd0, (i >= BL)});
      end
      idle_cycle();
      ren_mode = 0;
      wait_drain("overflow", 200);

      // reset in the middle of a drain
      push_burst(32'h50000, BL);
      for (int i = 0; i < BL; i++) write_cycle(32'h50000, i, 1'b0);
      idle_cycle();
      x0 = xfer_cnt;
      c = 0;
      while (xfer_cnt < x0 + 10 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("mid_drain_reached", {63'd0, (xfer_cnt >= x0 + 10)}, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("mid_reset");

      push_burst(32'h60000, BL);
      for (int i = 0; i < BL; i++) write_cycle(32'h60000, i, 1'b0);
      idle_cycle();
      wait_drain("after_reset", 200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
